// File: rtl/obi_ram_pkg.sv
// Shared types and constants for the multi-port OBI simulation RAM.
// Holds the response record carried through the latency pipe and the LFSR set-up.
package obi_ram_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } obi_rsp_t;

    // Fibonacci taps 16,14,13,11 for a right-shifting register (feedback into bit 15)
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int unsigned STALL_MAX  = 8;
    localparam int unsigned STALL_W    = $clog2(STALL_MAX);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

    // Folds a 32-bit seed into 16 bits; an all-zero state would lock the LFSR.
    function automatic logic [15:0] lfsr_seed(input logic [31:0] seed);
        logic [15:0] fold;
        fold = seed[31:16] ^ seed[15:0];
        return (fold == 16'h0) ? 16'h0001 : fold;
    endfunction

endpackage

// File: rtl/obi_rsp_delay.sv
// Fixed-latency response pipe: a LATENCY-deep shift register of obi_rsp_t.
// Each stage keeps its last valid rdata so the output data holds between responses.
import obi_ram_pkg::*;

module obi_rsp_delay #(
    parameter int unsigned LATENCY = 1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_rsp_t rsp_i,
    output obi_rsp_t rsp_o
);

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        obi_rsp_t src;
        obi_rsp_t stage_q;

        if (i == 0) begin : g_first
            assign src = rsp_i;
        end else begin : g_next
            assign src = g_stage[i-1].stage_q;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stage_q <= '0;
            end else begin
                stage_q.valid <= src.valid;
                if (src.valid) begin
                    stage_q.rdata <= src.rdata;
                end
            end
        end
    end

    assign rsp_o = g_stage[LATENCY-1].stage_q;

endmodule

// File: rtl/obi_multi_port_ram.sv
// Word RAM shared by NUM_PORTS OBI slave ports, with fixed read latency, optional
// LFSR grant back-pressure, sticky out-of-range flag and a mailbox completion monitor.
import obi_ram_pkg::*;

module obi_multi_port_ram #(
    parameter int unsigned NUM_PORTS     = 2,
    parameter int unsigned MEM_SIZE_WORD = 40960,
    parameter int unsigned LATENCY       = 1,
    parameter bit          RANDOM_GNT    = 1'b0,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_0001,
    parameter int unsigned DONE_WORD     = 40704,
    parameter logic [31:0] DONE_VALUE    = 32'd1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_PORTS-1:0]    req_i,
    input  logic [NUM_PORTS-1:0]    we_i,
    input  logic [NUM_PORTS*4-1:0]  be_i,
    input  logic [NUM_PORTS*32-1:0] addr_i,
    input  logic [NUM_PORTS*32-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]    gnt_o,
    output logic [NUM_PORTS-1:0]    rvalid_o,
    output logic [NUM_PORTS*32-1:0] rdata_o,
    output logic                    oor_o,
    output logic                    done_o
);

    localparam int unsigned AW = (MEM_SIZE_WORD > 1) ? $clog2(MEM_SIZE_WORD) : 1;

    logic [31:0]          mem_array [MEM_SIZE_WORD];
    logic [NUM_PORTS-1:0] xfer;
    logic [NUM_PORTS-1:0] in_range;
    logic [AW-1:0]        widx [NUM_PORTS];
    obi_rsp_t             rsp_in  [NUM_PORTS];
    obi_rsp_t             rsp_out [NUM_PORTS];

    logic        oor_q, oor_d;
    logic        done_q, done_d;
    logic        done_hit;
    logic [31:0] done_word;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [29:0] word;

        assign word        = addr_i[p*32+2 +: 30];
        assign in_range[p] = 32'(word) < MEM_SIZE_WORD;
        assign widx[p]     = word[AW-1:0];
        assign xfer[p]     = req_i[p] & gnt_o[p];

        // Read data is captured at the transfer edge, before this edge's writes land.
        assign rsp_in[p] = '{valid: xfer[p],
                             rdata: (!we_i[p] && in_range[p]) ? mem_array[widx[p]] : 32'h0};

        if (RANDOM_GNT) begin : g_rnd
            localparam logic [15:0] SEED = lfsr_seed(LFSR_SEED ^ 32'(p));
            logic [15:0]        lfsr_q, lfsr_d;
            logic [STALL_W-1:0] stall_q, stall_d;

            assign lfsr_d  = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
            assign stall_d = (!req_i[p] || gnt_o[p]) ? '0 : stall_q + 1'b1;
            // The eighth consecutive waiting cycle is granted regardless of the LFSR.
            assign gnt_o[p] = req_i[p] & (lfsr_q[0] | (stall_q == STALL_LAST));

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    lfsr_q  <= SEED;
                    stall_q <= '0;
                end else begin
                    lfsr_q  <= lfsr_d;
                    stall_q <= stall_d;
                end
            end
        end else begin : g_fix
            assign gnt_o[p] = req_i[p];
        end

        obi_rsp_delay #(
            .LATENCY (LATENCY)
        ) u_delay (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .rsp_i  (rsp_in[p]),
            .rsp_o  (rsp_out[p])
        );

        assign rvalid_o[p]          = rsp_out[p].valid;
        assign rdata_o[p*32 +: 32]  = rsp_out[p].rdata;
    end

    // Highest port is applied first so the lowest index wins each contested byte.
    always_ff @(posedge clk_i) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (xfer[p] && we_i[p] && in_range[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[p*4+b]) begin
                        mem_array[widx[p]][b*8 +: 8] <= wdata_i[p*32+b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        done_word = mem_array[DONE_WORD];
        done_hit  = 1'b0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (xfer[p] && we_i[p] && in_range[p] && (widx[p] == AW'(DONE_WORD))) begin
                done_hit = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (be_i[p*4+b]) begin
                        done_word[b*8 +: 8] = wdata_i[p*32+b*8 +: 8];
                    end
                end
            end
        end
        done_d = done_q | (done_hit && (done_word == DONE_VALUE));
        oor_d  = oor_q | (|(xfer & ~in_range));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oor_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            oor_q  <= oor_d;
            done_q <= done_d;
        end
    end

    assign oor_o  = oor_q;
    assign done_o = done_q;

endmodule
